// File: rtl/muxn_skid.sv
// rtl/muxn_skid.sv - N-way registered data mux with valid/ready handshake and 2-entry skid buffer
// Optional feature macro: MUXN_SEL_ERR_EN (adds sticky sel_err output for out-of-range selects)
module muxn_skid #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [SEL_WIDTH-1:0]         sel,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready
`ifdef MUXN_SEL_ERR_EN
  ,
  output logic                         sel_err
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;
  logic [DATA_WIDTH-1:0] sel_word;
  logic                  accept;
  logic                  emit;

`ifdef MUXN_SEL_ERR_EN
  logic                  sel_hit;
  logic                  sel_err_q, sel_err_d;
`endif

  assign accept = in_valid && in_ready_q;
  assign emit   = out_valid_q && out_ready;

  // Pick slice sel of in_data; indices past NUM_IN match nothing and give zero
  always_comb begin
    sel_word = '0;
`ifdef MUXN_SEL_ERR_EN
    sel_hit  = 1'b0;
`endif
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_WIDTH'(k)) begin
        sel_word = in_data[k*DATA_WIDTH +: DATA_WIDTH];
`ifdef MUXN_SEL_ERR_EN
        sel_hit  = 1'b1;
`endif
      end
    end
  end

  // Occupancy state machine: main register drives the output, skid catches one word during a stall
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_data_d = sel_word;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && emit) begin
          main_data_d = sel_word;
        end else if (accept) begin
          skid_data_d = sel_word;
          state_d     = ST_FULL;
        end else if (emit) begin
          state_d     = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (emit) begin
          main_data_d = skid_data_q;
          state_d     = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush drops everything, including a word accepted this same cycle; out_data keeps its old value
    if (flush) begin
      state_d     = ST_EMPTY;
      main_data_d = main_data_q;
      skid_data_d = skid_data_q;
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

`ifdef MUXN_SEL_ERR_EN
  // Sticky error: only reset clears it
  always_comb begin
    sel_err_d = sel_err_q | (accept && !sel_hit);
  end
`endif

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef MUXN_SEL_ERR_EN
      sel_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef MUXN_SEL_ERR_EN
      sel_err_q   <= sel_err_d;
`endif
    end
  end

  assign out_data  = main_data_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
`ifdef MUXN_SEL_ERR_EN
  assign sel_err   = sel_err_q;
`endif

endmodule

// File: tb/tb_muxn_skid.sv
// tb/tb_muxn_skid.sv - self-checking bench for muxn_skid (NUM_IN=4 table, NUM_IN=5 out-of-range sequence)
module tb_muxn_skid;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // NUM_IN=4 instance
  logic         rst_n4, in_valid4, in_ready4, flush4, out_valid4, out_ready4;
  logic [1:0]   sel4;
  logic [127:0] in_data4;
  logic [31:0]  out_data4;

  // NUM_IN=5 instance
  logic         rst_n5, in_valid5, in_ready5, flush5, out_valid5, out_ready5;
  logic [2:0]   sel5;
  logic [159:0] in_data5;
  logic [31:0]  out_data5;
`ifdef MUXN_SEL_ERR_EN
  logic         sel_err4, sel_err5;
`endif

  muxn_skid #(.DATA_WIDTH(32), .NUM_IN(4)) dut4 (
    .clk(clk), .rst_n(rst_n4), .in_data(in_data4), .sel(sel4),
    .in_valid(in_valid4), .in_ready(in_ready4), .flush(flush4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4)
`ifdef MUXN_SEL_ERR_EN
    , .sel_err(sel_err4)
`endif
  );

  muxn_skid #(.DATA_WIDTH(32), .NUM_IN(5)) dut5 (
    .clk(clk), .rst_n(rst_n5), .in_data(in_data5), .sel(sel5),
    .in_valid(in_valid5), .in_ready(in_ready5), .flush(flush5),
    .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready5)
`ifdef MUXN_SEL_ERR_EN
    , .sel_err(sel_err5)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  sel;
    logic        out_ready;
    logic        flush;
    logic        exp_valid;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic v, input logic [1:0] s, input logic o,
                              input logic f, input logic ev, input logic cd, input logic [31:0] ed,
                              input logic er);
    vec_t x;
    x.rst_n = r; x.in_valid = v; x.sel = s; x.out_ready = o; x.flush = f;
    x.exp_valid = ev; x.chk_data = cd; x.exp_data = ed; x.exp_ready = er;
    return x;
  endfunction

  initial begin
    // Reset held 2 cycles with in_valid high
    vecs.push_back(mk(0, 1, 2'd0, 1, 0, 0, 1, 32'h00, 1));
    vecs.push_back(mk(0, 1, 2'd0, 1, 0, 0, 1, 32'h00, 1));
    // Streaming, sel 0..3 twice, no bubbles
    vecs.push_back(mk(1, 1, 2'd0, 1, 0, 1, 1, 32'hA0, 1));
    vecs.push_back(mk(1, 1, 2'd1, 1, 0, 1, 1, 32'hB1, 1));
    vecs.push_back(mk(1, 1, 2'd2, 1, 0, 1, 1, 32'hC2, 1));
    vecs.push_back(mk(1, 1, 2'd3, 1, 0, 1, 1, 32'hD3, 1));
    vecs.push_back(mk(1, 1, 2'd0, 1, 0, 1, 1, 32'hA0, 1));
    vecs.push_back(mk(1, 1, 2'd1, 1, 0, 1, 1, 32'hB1, 1));
    vecs.push_back(mk(1, 1, 2'd2, 1, 0, 1, 1, 32'hC2, 1));
    vecs.push_back(mk(1, 1, 2'd3, 1, 0, 1, 1, 32'hD3, 1));
    vecs.push_back(mk(1, 0, 2'd0, 1, 0, 0, 0, 32'h00, 1));
    // Backpressure: fill to FULL, hold, drain in order
    vecs.push_back(mk(1, 1, 2'd1, 0, 0, 1, 1, 32'hB1, 1));
    vecs.push_back(mk(1, 1, 2'd2, 0, 0, 1, 1, 32'hB1, 0));
    vecs.push_back(mk(1, 1, 2'd3, 0, 0, 1, 1, 32'hB1, 0));
    vecs.push_back(mk(1, 0, 2'd0, 1, 0, 1, 1, 32'hC2, 1));
    vecs.push_back(mk(1, 0, 2'd0, 1, 0, 0, 0, 32'h00, 1));
    // Flush while FULL
    vecs.push_back(mk(1, 1, 2'd0, 0, 0, 1, 1, 32'hA0, 1));
    vecs.push_back(mk(1, 1, 2'd1, 0, 0, 1, 1, 32'hA0, 0));
    vecs.push_back(mk(1, 1, 2'd2, 0, 1, 0, 0, 32'h00, 1));
    vecs.push_back(mk(1, 0, 2'd0, 1, 0, 0, 0, 32'h00, 1));
    // Flush while ONE together with an accept
    vecs.push_back(mk(1, 1, 2'd3, 0, 0, 1, 1, 32'hD3, 1));
    vecs.push_back(mk(1, 1, 2'd0, 0, 1, 0, 0, 32'h00, 1));
    vecs.push_back(mk(1, 0, 2'd0, 1, 0, 0, 0, 32'h00, 1));
    // Mid-operation reset while FULL
    vecs.push_back(mk(1, 1, 2'd2, 0, 0, 1, 1, 32'hC2, 1));
    vecs.push_back(mk(1, 1, 2'd3, 0, 0, 1, 1, 32'hC2, 0));
    vecs.push_back(mk(0, 1, 2'd1, 1, 0, 0, 1, 32'h00, 1));
    vecs.push_back(mk(1, 0, 2'd0, 1, 0, 0, 1, 32'h00, 1));
    vecs.push_back(mk(1, 1, 2'd1, 1, 0, 1, 1, 32'hB1, 1));
    vecs.push_back(mk(1, 0, 2'd0, 1, 0, 0, 0, 32'h00, 1));

    in_data4 = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
    in_data5 = {32'h14, 32'h13, 32'h12, 32'h11, 32'h10};
    rst_n4 = 0; in_valid4 = 0; sel4 = 0; out_ready4 = 0; flush4 = 0;
    rst_n5 = 0; in_valid5 = 0; sel5 = 0; out_ready5 = 1; flush5 = 0;

    // Table-driven run on the NUM_IN=4 instance
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n4 = vecs[i].rst_n; in_valid4 = vecs[i].in_valid; sel4 = vecs[i].sel;
      out_ready4 = vecs[i].out_ready; flush4 = vecs[i].flush;
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), {31'b0, out_valid4}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("v%0d in_ready", i), {31'b0, in_ready4}, {31'b0, vecs[i].exp_ready});
      if (vecs[i].chk_data) chk($sformatf("v%0d out_data", i), out_data4, vecs[i].exp_data);
    end
    in_valid4 = 0;

    // NUM_IN=5: reset, then out-of-range and boundary selects
    rst_n5 = 0; in_valid5 = 1; sel5 = 3'd7;
    @(posedge clk); #1;
    chk("n5 rst out_valid", {31'b0, out_valid5}, 32'd0);
`ifdef MUXN_SEL_ERR_EN
    chk("n5 rst sel_err", {31'b0, sel_err5}, 32'd0);
`endif
    rst_n5 = 1; sel5 = 3'd7;
    @(posedge clk); #1;
    chk("n5 sel7 out_valid", {31'b0, out_valid5}, 32'd1);
    chk("n5 sel7 out_data", out_data5, 32'h0);
`ifdef MUXN_SEL_ERR_EN
    chk("n5 sel7 sel_err", {31'b0, sel_err5}, 32'd1);
`endif
    sel5 = 3'd4;
    @(posedge clk); #1;
    chk("n5 sel4 out_data", out_data5, 32'h14);
    sel5 = 3'd5;
    @(posedge clk); #1;
    chk("n5 sel5 out_data", out_data5, 32'h0);
    chk("n5 sel5 out_valid", {31'b0, out_valid5}, 32'd1);
    in_valid5 = 0; flush5 = 1;
    @(posedge clk); #1;
    chk("n5 flush out_valid", {31'b0, out_valid5}, 32'd0);
`ifdef MUXN_SEL_ERR_EN
    chk("n5 flush sel_err", {31'b0, sel_err5}, 32'd1);
`endif
    flush5 = 0; rst_n5 = 0;
    @(posedge clk); #1;
    chk("n5 rst2 out_data", out_data5, 32'h0);
`ifdef MUXN_SEL_ERR_EN
    chk("n5 rst2 sel_err", {31'b0, sel_err5}, 32'd0);
`endif
    rst_n5 = 1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
